// File: rtl/sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module   : sequence_checker
//  Purpose  : Receive-side checker for the 8-byte repeating test pattern
//             AF BC E2 78 FF E2 0B 8D. It hunts for AF and then verifies a
//             full frame before declaring lock. While locked it checks every
//             qualified byte, counts mismatches in a saturating counter and
//             drops lock after MISS_LIMIT consecutive mismatches.
//
//  Parameters:
//    ERR_W       width of the saturating error counter (>= 2)
//    MISS_LIMIT  consecutive mismatches in LOCKED that force HUNT (1..15)
//
//  Ports:
//    clk          in   rising-edge clock
//    reset_n      in   asynchronous active-low reset
//    valid        in   data carries a pattern byte this cycle
//    data[7:0]    in   received byte
//    err_clr      in   synchronous error-counter clear
//                      (only when SEQ_CHECKER_ERR_CLR_EN is defined)
//    locked       out  checker aligned to the pattern
//    err_pulse    out  one-cycle pulse per mismatching byte while locked
//    frame_pulse  out  one-cycle pulse when a correct 8D ends a locked frame
//    err_count    out  saturating mismatch count (ERR_W bits)
//
//  Optional feature macro: SEQ_CHECKER_ERR_CLR_EN adds the err_clr input.
//
//  Revision : 1.0  initial release
// ============================================================================
module sequence_checker #(
  parameter int ERR_W      = 16,
  parameter int MISS_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [7:0]       data,
`ifdef SEQ_CHECKER_ERR_CLR_EN
  input  logic             err_clr,
`endif
  output logic             locked,
  output logic             err_pulse,
  output logic             frame_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       FIRST_BYTE = 8'hAF;
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       MISS_LIM   = 4'(MISS_LIMIT);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] miss;

  logic [7:0] expected;
  logic       match;
  logic [3:0] miss_next;
  logic       clr_req;

  // Expected byte for the current pattern position.
  always_comb begin
    expected = FIRST_BYTE;
    unique case (idx)
      3'd0: expected = 8'hAF;
      3'd1: expected = 8'hBC;
      3'd2: expected = 8'hE2;
      3'd3: expected = 8'h78;
      3'd4: expected = 8'hFF;
      3'd5: expected = 8'hE2;
      3'd6: expected = 8'h0B;
      3'd7: expected = 8'h8D;
      default: expected = FIRST_BYTE;
    endcase
  end

  assign match     = (data == expected);
  assign miss_next = miss + 4'd1;

`ifdef SEQ_CHECKER_ERR_CLR_EN
  assign clr_req = err_clr;
`else
  assign clr_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      idx         <= 3'd0;
      miss        <= 4'd0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      frame_pulse <= 1'b0;
      err_count   <= '0;
    end else begin
      err_pulse   <= 1'b0;
      frame_pulse <= 1'b0;

      // Clear wins over a same-cycle increment (increment below is gated).
      if (clr_req) begin
        err_count <= '0;
      end

      if (valid) begin
        unique case (state)
          HUNT: begin
            if (data == FIRST_BYTE) begin
              state <= VERIFY;
              idx   <= 3'd1;
            end
          end

          VERIFY: begin
            if (match) begin
              if (idx == 3'd7) begin
                state  <= LOCKED;
                idx    <= 3'd0;
                locked <= 1'b1;
              end else begin
                idx <= idx + 3'd1;
              end
            end else if (data == FIRST_BYTE) begin
              // A stray AF mid-verify may be the real frame start.
              idx <= 3'd1;
            end else begin
              state <= HUNT;
              idx   <= 3'd0;
            end
          end

          LOCKED: begin
            // Position tracks the generator regardless of byte correctness.
            idx <= idx + 3'd1;
            if (match) begin
              miss        <= 4'd0;
              frame_pulse <= (idx == 3'd7);
            end else begin
              err_pulse <= 1'b1;
              if (!clr_req && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_ONE;
              end
              if (miss_next == MISS_LIM) begin
                state  <= HUNT;
                idx    <= 3'd0;
                miss   <= 4'd0;
                locked <= 1'b0;
              end else begin
                miss <= miss_next;
              end
            end
          end

          default: begin
            state <= HUNT;
            idx   <= 3'd0;
            miss  <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
